// File: rtl/eyearch_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   ADDR_W_DEFAULT : default PROM word-address / PC width
//   DATA_W_DEFAULT : default instruction width
//   fetch_entry_t  : one prefetch FIFO entry {fetch address, instruction}
package eyearch_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 16;
    localparam int unsigned DATA_W_DEFAULT = 32;

    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] pc;
        logic [DATA_W_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: PROM read port, decode handshake and branch redirect.
//   fetch_en                 : fetch allowed (1) / hold PC and drain (0)
//   prom_read/prom_addr      : PROM read strobe and word address
//   prom_instr               : PROM data, valid in the prom_read cycle
//   instr_valid/instr_ready  : head-of-FIFO handshake towards decode
//   instr_data/instr_pc      : head instruction and its fetch address
//   redirect_valid/_pc       : load new PC and flush prefetched words
// master = fetch unit, slave = PROM/decode environment.
interface instr_fetch_if
    import eyearch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
);

    logic              fetch_en;
    logic              prom_read;
    logic [ADDR_W-1:0] prom_addr;
    logic [DATA_W-1:0] prom_instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        input  fetch_en,
        output prom_read, prom_addr,
        input  prom_instr,
        output instr_valid,
        input  instr_ready,
        output instr_data, instr_pc,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        output fetch_en,
        input  prom_read, prom_addr,
        output prom_instr,
        input  instr_valid,
        output instr_ready,
        input  instr_data, instr_pc,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of DEPTH entries with write/read pointers and an occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empty the FIFO (wins over push/pop); storage is left intact
//   push, din  : write din at the tail (caller guarantees room or a same-cycle pop)
//   pop        : drop the head (caller guarantees count != 0)
//   head       : entry at the read pointer
//   count      : occupancy, 0..DEPTH
module fetch_fifo
    import eyearch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  entry_t                     din,
    output entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i[PW-1:0]] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: program counter, PROM read strobe and prefetch FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_if master (PROM port, decode handshake, redirect)
// One PROM word is read per cycle while fetching is allowed and the FIFO has
// room (or is being popped); redirect flushes the FIFO and reloads the PC.
module instr_fetch
    import eyearch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
    parameter int unsigned       DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc;
    logic              pop;
    logic              fetch;
    logic [CW-1:0]     fifo_count;
    entry_t            push_entry;
    entry_t            head;

    assign pop = bus.instr_valid & bus.instr_ready;

    // rst_n gates the strobe so no read escapes while reset is held.
    assign fetch = rst_n & bus.fetch_en & ~bus.redirect_valid
                 & ((fifo_count < CW'(DEPTH)) | pop);

    assign bus.prom_read   = fetch;
    assign bus.prom_addr   = pc;
    assign push_entry      = '{pc: pc, instr: bus.prom_instr};
    assign bus.instr_valid = (fifo_count != '0);
    assign bus.instr_data  = head.instr;
    assign bus.instr_pc    = head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= bus.redirect_pc;
        end else if (fetch) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect_valid),
        .push  (fetch),
        .pop   (pop & ~bus.redirect_valid),
        .din   (push_entry),
        .head  (head),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic clk;
    logic rst_n;

    instr_fetch_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    instr_fetch #(
        .ADDR_W   (16),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural PROM: mem[a] = 32'hA000_0000 | a
    assign bus.prom_instr = 32'hA000_0000 | {16'h0000, bus.prom_addr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        fe;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        e_read;
        logic [15:0] e_addr;
        logic        e_valid;
        logic        chk_head;
        logic [15:0] e_pc;
    } vec_t;

    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        have_prev = 1'b0;
    logic [15:0] prev_pc   = '0;

    function automatic vec_t mk(input logic r, input logic f, input logic y,
                                input logic v, input logic [15:0] rp,
                                input logic er, input logic [15:0] ea,
                                input logic ev, input logic ch,
                                input logic [15:0] ep);
        vec_t t;
        t.rst = r; t.fe = f; t.rdy = y; t.redir = v; t.rpc = rp;
        t.e_read = er; t.e_addr = ea; t.e_valid = ev; t.chk_head = ch; t.e_pc = ep;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle properties: occupancy bound, no read during redirect,
    // sequential instr_pc between pops unless reset/redirect intervenes.
    task automatic assert_step(input string tag);
        logic [15:0] nxt;
        chk({tag, " count<=DEPTH"}, {31'b0, (dut.u_fifo.count <= 3'd4)}, 32'd1);
        if (bus.prom_read) begin
            chk({tag, " read_vs_redirect"}, {31'b0, bus.redirect_valid}, 32'd0);
        end
        if (!rst_n || bus.redirect_valid) begin
            have_prev = 1'b0;
        end else if (bus.instr_valid && bus.instr_ready) begin
            if (have_prev) begin
                nxt = prev_pc + 16'd1;
                chk({tag, " pc_seq"}, {16'h0, bus.instr_pc}, {16'h0, nxt});
            end
            prev_pc   = bus.instr_pc;
            have_prev = 1'b1;
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.fetch_en       = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // rst fe rdy redir rpc | read addr valid chk pc
        // 1: reset, stream 0..3
        vecs.push_back(mk(0,1,1,0,16'h0000, 0,16'h0000,0,1,16'h0000));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0000,0,0,16'h0000));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0001,1,1,16'h0000));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0002,1,1,16'h0001));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0003,1,1,16'h0002));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0004,1,1,16'h0003));
        // 2: reset, fill with ready=0, then pop+fetch while full
        vecs.push_back(mk(0,1,0,0,16'h0000, 0,16'h0000,0,1,16'h0000));
        vecs.push_back(mk(1,1,0,0,16'h0000, 1,16'h0000,0,0,16'h0000));
        vecs.push_back(mk(1,1,0,0,16'h0000, 1,16'h0001,1,1,16'h0000));
        vecs.push_back(mk(1,1,0,0,16'h0000, 1,16'h0002,1,1,16'h0000));
        vecs.push_back(mk(1,1,0,0,16'h0000, 1,16'h0003,1,1,16'h0000));
        vecs.push_back(mk(1,1,0,0,16'h0000, 0,16'h0004,1,1,16'h0000));
        vecs.push_back(mk(1,1,0,0,16'h0000, 0,16'h0004,1,1,16'h0000));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0004,1,1,16'h0000));
        vecs.push_back(mk(1,1,0,0,16'h0000, 0,16'h0005,1,1,16'h0001));
        // 5: fetch_en=0, drain
        vecs.push_back(mk(1,0,1,0,16'h0000, 0,16'h0005,1,1,16'h0001));
        vecs.push_back(mk(1,0,1,0,16'h0000, 0,16'h0005,1,1,16'h0002));
        vecs.push_back(mk(1,0,1,0,16'h0000, 0,16'h0005,1,1,16'h0003));
        vecs.push_back(mk(1,0,1,0,16'h0000, 0,16'h0005,1,1,16'h0004));
        vecs.push_back(mk(1,0,1,0,16'h0000, 0,16'h0005,0,0,16'h0000));
        vecs.push_back(mk(1,0,0,0,16'h0000, 0,16'h0005,0,0,16'h0000));
        // 3: stream then redirect to 0x0100
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0005,0,0,16'h0000));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0006,1,1,16'h0005));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0007,1,1,16'h0006));
        vecs.push_back(mk(1,1,1,1,16'h0100, 0,16'h0008,1,1,16'h0007));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0100,0,0,16'h0000));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0101,1,1,16'h0100));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0102,1,1,16'h0101));
        // 4: redirect to 0xFFFE, PC wraps
        vecs.push_back(mk(1,1,1,1,16'hFFFE, 0,16'h0103,1,1,16'h0102));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'hFFFE,0,0,16'h0000));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'hFFFF,1,1,16'hFFFE));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0000,1,1,16'hFFFF));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0001,1,1,16'h0000));
        vecs.push_back(mk(1,1,1,0,16'h0000, 1,16'h0002,1,1,16'h0001));

        foreach (vecs[i]) begin
            logic [31:0] e_data;
            @(negedge clk);
            rst_n              = vecs[i].rst;
            bus.fetch_en       = vecs[i].fe;
            bus.instr_ready    = vecs[i].rdy;
            bus.redirect_valid = vecs[i].redir;
            bus.redirect_pc    = vecs[i].rpc;
            #1;
            chk($sformatf("r%0d prom_read", i), {31'b0, bus.prom_read}, {31'b0, vecs[i].e_read});
            chk($sformatf("r%0d prom_addr", i), {16'h0, bus.prom_addr}, {16'h0, vecs[i].e_addr});
            chk($sformatf("r%0d instr_valid", i), {31'b0, bus.instr_valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].chk_head) begin
                e_data = vecs[i].rst ? (32'hA000_0000 | {16'h0, vecs[i].e_pc}) : 32'h0;
                chk($sformatf("r%0d instr_pc", i), {16'h0, bus.instr_pc}, {16'h0, vecs[i].e_pc});
                chk($sformatf("r%0d instr_data", i), bus.instr_data, e_data);
            end
            assert_step($sformatf("r%0d", i));
        end

        // 6: asynchronous reset mid-stream, away from a clock edge
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.fetch_en = 1'b1; bus.instr_ready = 1'b1; bus.redirect_valid = 1'b0;
            #1;
            assert_step($sformatf("s%0d", k));
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("async_rst prom_read", {31'b0, bus.prom_read}, 32'd0);
        chk("async_rst prom_addr", {16'h0, bus.prom_addr}, 32'h0000);
        have_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst prom_read", {31'b0, bus.prom_read}, 32'd1);
        chk("post_rst prom_addr", {16'h0, bus.prom_addr}, 32'h0000);
        chk("post_rst instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        assert_step("p0");
        @(negedge clk);
        #1;
        chk("post_rst1 instr_valid", {31'b0, bus.instr_valid}, 32'd1);
        chk("post_rst1 instr_pc", {16'h0, bus.instr_pc}, 32'h0000);
        chk("post_rst1 instr_data", bus.instr_data, 32'hA000_0000);
        chk("post_rst1 prom_addr", {16'h0, bus.prom_addr}, 32'h0001);
        assert_step("p1");
        @(negedge clk);
        #1;
        chk("post_rst2 instr_pc", {16'h0, bus.instr_pc}, 32'h0001);
        chk("post_rst2 instr_data", bus.instr_data, 32'hA000_0001);
        assert_step("p2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
